// File: rtl/eth_udp_tx_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP transmit path.
// Header layouts are packed structs so that the MSB of each struct is the first byte on the wire.
package eth_udp_tx_pkg;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_ETH_HDR,
        TX_IP_HDR,
        TX_UDP_HDR,
        TX_PAYLOAD,
        TX_PAD,
        TX_FCS,
        TX_IFG
    } eth_tx_states;

    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
    localparam logic [7:0]  PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam int          MIN_PAYLOAD_AREA = 46;

    localparam logic [15:0] MAX_PAYLOAD    = 16'd1472;
    localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
    localparam logic [15:0] MIN_PAYLOAD    = 16'(MIN_PAYLOAD_AREA - 28);

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } eth_hdr_t;

    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] tot_len;
        logic [15:0] ident;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] csum;
    } udp_hdr_t;

    // Checksum field is forced to zero before summing, so callers may pass a live header.
    function automatic logic [15:0] ipv4_csum(input ipv4_hdr_t h);
        logic [159:0] flat;
        logic [19:0]  sum;
        h.csum = '0;
        flat   = h;
        sum    = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {4'b0, flat[16*i +: 16]};
        end
        sum = {4'b0, sum[15:0]} + {16'b0, sum[19:16]};
        sum = {4'b0, sum[15:0]} + {16'b0, sum[19:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/eth_udp_tx_if.sv
// Request, payload-pull and frame-byte streams of the UDP transmitter.
// slave is the transmitter side; master is the user/serializer side.
interface eth_udp_tx_if;
    logic        start;
    logic [47:0] dest_mac;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic [15:0] payload_len;
    logic        busy;

    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;

    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        tx_underrun;

    modport slave (
        input  start, dest_mac, dest_ip, dest_port, payload_len,
        input  pay_data, pay_valid, tx_ready,
        output busy, pay_ready, tx_byte, tx_valid, tx_last, tx_underrun
    );

    modport master (
        output start, dest_mac, dest_ip, dest_port, payload_len,
        output pay_data, pay_valid, tx_ready,
        input  busy, pay_ready, tx_byte, tx_valid, tx_last, tx_underrun
    );
endinterface

// File: rtl/eth_udp_tx_crc32_d8.sv
// One byte of reflected CRC-32 per call, purely combinational; reused by the RX FCS checker.
// Latency: 0 cycles. Backpressure: none, the caller decides when to register crc_out.
module crc32_d8
    import eth_udp_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] stage [0:8];

    assign stage[0] = crc_in ^ {24'h0, data};

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign stage[i+1] = stage[i][0] ? ((stage[i] >> 1) ^ CRC32_POLY_REFL) : (stage[i] >> 1);
    end

    assign crc_out = stage[8];

endmodule

// File: rtl/eth_udp_tx.sv
// Builds one Ethernet II/IPv4/UDP frame per accepted start: preamble, headers, payload, pad, FCS, IFG.
// Latency: first preamble byte is offered the cycle after start is accepted, then one byte per transfer.
// Backpressure: all byte counters advance only on tx_valid&tx_ready; payload is pulled only while tx_ready.
module eth_udp_tx
    import eth_udp_tx_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC   = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP    = 32'hC0_00_02_92,
    parameter logic [15:0] FPGA_PORT  = 16'd5005,
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter int          IFG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        reset,
    eth_udp_tx_if.slave bus
);

    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    eth_tx_states state, state_nxt;
    logic [15:0]  cnt, cnt_nxt;

    logic [47:0]  mac_q;
    logic [31:0]  ip_q;
    logic [15:0]  port_q;
    logic [15:0]  len_q;
    logic [15:0]  ident;
    logic [15:0]  csum_q;
    logic [31:0]  crc, crc_step, fcs;

    eth_hdr_t     eth_hdr;
    ipv4_hdr_t    ip_hdr;
    udp_hdr_t     udp_hdr;
    logic [111:0] eth_vec;
    logic [159:0] ip_vec;
    logic [63:0]  udp_vec;

    logic         start_ok, xfer, last_in_state, crc_en;
    logic [15:0]  pad_len;

    assign start_ok = bus.start && (bus.payload_len <= MAX_PAYLOAD);
    assign xfer     = bus.tx_valid && bus.tx_ready;
    assign pad_len  = MIN_PAYLOAD - len_q;
    assign crc_en   = state inside {TX_ETH_HDR, TX_IP_HDR, TX_UDP_HDR, TX_PAYLOAD, TX_PAD};
    assign fcs      = ~crc;

    always_comb begin
        eth_hdr.dst_mac    = mac_q;
        eth_hdr.src_mac    = FPGA_MAC;
        eth_hdr.ethertype  = ETHERTYPE_IPV4;

        ip_hdr.ver_ihl     = 8'h45;
        ip_hdr.tos         = 8'h00;
        ip_hdr.tot_len     = len_q + IP_UDP_HDR_LEN;
        ip_hdr.ident       = ident;
        ip_hdr.flags_frag  = 16'h4000;
        ip_hdr.ttl         = IP_TTL;
        ip_hdr.proto       = IP_PROTO_UDP;
        ip_hdr.csum        = csum_q;
        ip_hdr.src_ip      = FPGA_IP;
        ip_hdr.dst_ip      = ip_q;

        udp_hdr.src_port   = FPGA_PORT;
        udp_hdr.dst_port   = port_q;
        udp_hdr.length     = len_q + UDP_HDR_LEN;
        udp_hdr.csum       = 16'h0000;

        eth_vec = eth_hdr;
        ip_vec  = ip_hdr;
        udp_vec = udp_hdr;
    end

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (bus.tx_byte),
        .crc_out (crc_step)
    );

    always_comb begin
        last_in_state = 1'b0;
        case (state)
            TX_PREAMBLE: last_in_state = (cnt == 16'd7);
            TX_ETH_HDR:  last_in_state = (cnt == 16'd13);
            TX_IP_HDR:   last_in_state = (cnt == 16'd19);
            TX_UDP_HDR:  last_in_state = (cnt == 16'd7);
            TX_PAYLOAD:  last_in_state = (cnt == len_q - 16'd1);
            TX_PAD:      last_in_state = (cnt == pad_len - 16'd1);
            TX_FCS:      last_in_state = (cnt == 16'd3);
            default:     last_in_state = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            TX_IDLE: begin
                if (start_ok) begin
                    state_nxt = TX_PREAMBLE;
                    cnt_nxt   = '0;
                end
            end
            TX_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_nxt = TX_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                if (xfer) begin
                    if (last_in_state) begin
                        cnt_nxt = '0;
                        case (state)
                            TX_PREAMBLE: state_nxt = TX_ETH_HDR;
                            TX_ETH_HDR:  state_nxt = TX_IP_HDR;
                            TX_IP_HDR:   state_nxt = TX_UDP_HDR;
                            TX_UDP_HDR:  state_nxt = (len_q != 16'd0) ? TX_PAYLOAD : TX_PAD;
                            TX_PAYLOAD:  state_nxt = (len_q < MIN_PAYLOAD) ? TX_PAD : TX_FCS;
                            TX_PAD:      state_nxt = TX_FCS;
                            TX_FCS:      state_nxt = TX_IFG;
                            default:     state_nxt = TX_IDLE;
                        endcase
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
            end
        endcase
    end

    // Underrun substitutes a zero byte so the frame length fixed by the header never changes.
    always_comb begin
        bus.busy        = (state != TX_IDLE);
        bus.tx_valid    = state inside {TX_PREAMBLE, TX_ETH_HDR, TX_IP_HDR, TX_UDP_HDR,
                                        TX_PAYLOAD, TX_PAD, TX_FCS};
        bus.tx_last     = (state == TX_FCS) && (cnt == 16'd3);
        bus.pay_ready   = (state == TX_PAYLOAD) && bus.tx_ready;
        bus.tx_underrun = bus.pay_ready && !bus.pay_valid;
        bus.tx_byte     = 8'h00;
        case (state)
            TX_PREAMBLE: bus.tx_byte = (cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
            TX_ETH_HDR:  bus.tx_byte = eth_vec[{4'd13 - cnt[3:0], 3'b000} +: 8];
            TX_IP_HDR:   bus.tx_byte = ip_vec[{5'd19 - cnt[4:0], 3'b000} +: 8];
            TX_UDP_HDR:  bus.tx_byte = udp_vec[{3'd7 - cnt[2:0], 3'b000} +: 8];
            TX_PAYLOAD:  bus.tx_byte = bus.pay_valid ? bus.pay_data : 8'h00;
            TX_FCS:      bus.tx_byte = fcs[{cnt[1:0], 3'b000} +: 8];
            default:     bus.tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= TX_IDLE;
            cnt    <= '0;
            mac_q  <= '0;
            ip_q   <= '0;
            port_q <= '0;
            len_q  <= '0;
            ident  <= '0;
            csum_q <= '0;
            crc    <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == TX_IDLE && start_ok) begin
                mac_q  <= bus.dest_mac;
                ip_q   <= bus.dest_ip;
                port_q <= bus.dest_port;
                len_q  <= bus.payload_len;
                crc    <= '1;
            end else if (xfer && crc_en) begin
                crc <= crc_step;
            end
            // Header fields are frozen during the preamble, so the checksum settles well before IP byte 10.
            if (state == TX_PREAMBLE) begin
                csum_q <= ipv4_csum(ip_hdr);
            end
            if (state == TX_IFG && state_nxt == TX_IDLE) begin
                ident <= ident + 16'd1;
            end
        end
    end

endmodule
